// File: rtl/mdio_rw_engine.sv
// Clause-22 MDIO master: free-running MDC divider plus a 64-slot frame serializer
// that runs one read or write management frame per accepted request.
module mdio_rw_engine #(
  parameter int unsigned REF_CLK = 100,
  parameter int unsigned MDC_CLK = 500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        mdc_o,
  inout  wire         mdio_io,
  input  logic [4:0]  phy_addr_i,
  input  logic [4:0]  reg_addr_i,
  input  logic        write_req_i,
  input  logic [15:0] write_data_i,
  input  logic        read_req_i,
  output logic [15:0] read_data_o,
  output logic        data_valid_o,
  output logic        done_o,
  output logic [7:0]  debug_o
);

  localparam int unsigned Half = REF_CLK * 1000 / (2 * MDC_CLK);
  localparam int unsigned DivW = (Half > 1) ? $clog2(Half) : 1;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StWaitEdge = 4'd1,
    StShift    = 4'd2,
    StDone     = 4'd3
  } state_e;

  state_e      state_q, state_d;
  logic [DivW-1:0] div_q;
  logic        mdc_q;
  logic        is_write_q, is_write_d;
  logic [5:0]  slot_q, slot_d;
  logic [31:0] frame_q, frame_d;
  logic [15:0] rd_shift_q, rd_shift_d;
  logic [15:0] read_data_q, read_data_d;
  logic [1:0]  sync_q;

  logic div_tc, rise_evt, fall_evt;
  logic mdio_oe, mdio_out;

  assign div_tc   = (div_q == DivW'(Half - 1));
  assign rise_evt = div_tc & ~mdc_q;
  assign fall_evt = div_tc & mdc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q       <= '0;
      mdc_q       <= 1'b0;
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      slot_q      <= '0;
      frame_q     <= '0;
      rd_shift_q  <= '0;
      read_data_q <= '0;
      sync_q      <= '0;
    end else begin
      if (div_tc) begin
        div_q <= '0;
        mdc_q <= ~mdc_q;
      end else begin
        div_q <= div_q + DivW'(1);
      end
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      rd_shift_q  <= rd_shift_d;
      read_data_q <= read_data_d;
      sync_q      <= {sync_q[0], mdio_io};
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    slot_d      = slot_q;
    frame_d     = frame_q;
    rd_shift_d  = rd_shift_q;
    read_data_d = read_data_q;
    unique case (state_q)
      StIdle: begin
        if (write_req_i || read_req_i) begin
          is_write_d = write_req_i;
          state_d    = StWaitEdge;
        end
      end
      StWaitEdge: begin
        if (fall_evt) begin
          slot_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (rise_evt && !is_write_q && (slot_q >= 6'd48)) begin
          rd_shift_d = {rd_shift_q[14:0], sync_q[1]};
        end
        if (fall_evt) begin
          if (slot_q == 6'd63) begin
            state_d = StDone;
            if (!is_write_q) read_data_d = rd_shift_q;
          end else begin
            slot_d = slot_q + 6'd1;
            // Addresses and payload are captured only as ST starts, so callers may update late.
            if (slot_q == 6'd31) begin
              frame_d = {2'b01, (is_write_q ? 2'b01 : 2'b10), phy_addr_i, reg_addr_i,
                         2'b10, write_data_i};
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reads release the line from the turnaround onward; the PHY owns slots 46..63.
  assign mdio_oe  = (state_q == StShift) && (is_write_q || (slot_q < 6'd46));
  assign mdio_out = slot_q[5] ? frame_q[~slot_q[4:0]] : 1'b1;
  assign mdio_io  = mdio_oe ? mdio_out : 1'bz;

  assign mdc_o        = mdc_q;
  assign done_o       = (state_q == StDone);
  assign data_valid_o = (state_q == StDone) && !is_write_q;
  assign read_data_o  = read_data_q;
  assign debug_o      = {state_q, mdc_q, sync_q[1], mdio_oe, (state_q != StIdle)};

endmodule

// File: tb/tb_mdio_rw_engine.sv
// Directed bench for mdio_rw_engine: frame contents, MDC timing, late address,
// busy/simultaneous requests and mid-frame reset.
module tb_mdio_rw_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  phy_addr, reg_addr;
  logic        write_req, read_req;
  logic [15:0] write_data;
  logic        mdc, data_valid, done;
  logic [15:0] read_data;
  logic [7:0]  debug;
  wire         mdio;
  logic        phy_oe, phy_out;

  assign mdio = phy_oe ? phy_out : 1'bz;

  logic        mdc2, data_valid2, done2;
  logic [15:0] read_data2;
  logic [7:0]  debug2;
  wire         mdio2;
  logic [4:0]  zero5;
  logic [15:0] zero16;
  logic        zero1;

  mdio_rw_engine dut (
    .clk_i(clk), .rst_i(rst), .mdc_o(mdc), .mdio_io(mdio),
    .phy_addr_i(phy_addr), .reg_addr_i(reg_addr), .write_req_i(write_req),
    .write_data_i(write_data), .read_req_i(read_req), .read_data_o(read_data),
    .data_valid_o(data_valid), .done_o(done), .debug_o(debug)
  );

  mdio_rw_engine #(.REF_CLK(50), .MDC_CLK(2500)) dut2 (
    .clk_i(clk), .rst_i(rst), .mdc_o(mdc2), .mdio_io(mdio2),
    .phy_addr_i(zero5), .reg_addr_i(zero5), .write_req_i(zero1),
    .write_data_i(zero16), .read_req_i(zero1), .read_data_o(read_data2),
    .data_valid_o(data_valid2), .done_o(done2), .debug_o(debug2)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int dv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (data_valid === 1'b1) dv_cnt <= dv_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_mdc(input bit sel);
    return sel ? mdc2 : mdc;
  endfunction

  task automatic wait_mdc(input logic lvl, input bit sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (get_mdc(sel) === lvl) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_shift(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (debug[7:4] === 4'd2) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic measure(input bit sel, output int hi, output int lo, output bit ok);
    bit o;
    hi = 0;
    lo = 0;
    wait_mdc(1'b0, sel, o);
    ok = o;
    wait_mdc(1'b1, sel, o);
    ok = ok & o;
    while (get_mdc(sel) === 1'b1 && hi < 1000) begin
      @(negedge clk);
      hi++;
    end
    while (get_mdc(sel) === 1'b0 && lo < 1000) begin
      @(negedge clk);
      lo++;
    end
  endtask

  // Captures mdio/oe on each MDC rise; optional PHY drives TA=0 and phy_word on falls.
  task automatic run_frame(input bit phy_en, input logic [15:0] phy_word, input int inject_at,
                           output logic [63:0] bits, output logic [63:0] oes,
                           output logic done_seen, output logic dv_seen,
                           output logic [15:0] rd_at_done, output int cyc_done, output bit ok);
    bit o;
    int s;
    bits = '0;
    oes = '0;
    done_seen = 1'b0;
    dv_seen = 1'b0;
    rd_at_done = '0;
    cyc_done = 0;
    wait_shift(ok);
    if (!ok) return;
    for (int i = 0; i < 64; i++) begin
      wait_mdc(1'b1, 1'b0, o);
      if (!o) begin
        ok = 1'b0;
        return;
      end
      bits[63-i] = mdio;
      oes[63-i] = debug[1];
      if (i == inject_at) begin
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
      end
      wait_mdc(1'b0, 1'b0, o);
      if (!o) begin
        ok = 1'b0;
        return;
      end
      s = i + 1;
      if (phy_en && s >= 46 && s <= 63) begin
        phy_oe = 1'b1;
        phy_out = (s < 48) ? 1'b0 : phy_word[63-s];
      end else begin
        phy_oe = 1'b0;
      end
    end
    done_seen = done;
    dv_seen = data_valid;
    rd_at_done = read_data;
    cyc_done = cyc;
  endtask

  logic [63:0] bits, oes;
  logic        done_seen, dv_seen;
  logic [15:0] rd_at_done;
  int          cyc_done, c0, lat, dc0, dv0, hi, lo;
  bit          ok;

  initial begin
    rst = 1'b1;
    phy_addr = '0;
    reg_addr = '0;
    write_req = 1'b0;
    read_req = 1'b0;
    write_data = '0;
    phy_oe = 1'b0;
    phy_out = 1'b0;
    zero5 = '0;
    zero16 = '0;
    zero1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mdc", mdc, 0);
    check("rst_done", done, 0);
    check("rst_dv", data_valid, 0);
    check("rst_rdata", read_data, 0);
    check("rst_debug", debug & 8'hFB, 0);
    check("rst_dut2", {read_data2, done2, data_valid2, debug2 & 8'hFB}, 0);
    rst = 1'b0;

    // MDC timing at both parameter sets
    measure(1'b0, hi, lo, ok);
    check("mdc_ok", ok, 1);
    check("mdc_high", hi, 100);
    check("mdc_low", lo, 100);
    measure(1'b1, hi, lo, ok);
    check("mdc2_ok", ok, 1);
    check("mdc2_high", hi, 10);
    check("mdc2_low", lo, 10);

    // Write frame
    dc0 = done_cnt;
    dv0 = dv_cnt;
    @(negedge clk);
    phy_addr = 5'd1;
    reg_addr = 5'h16;
    write_data = 16'h0012;
    write_req = 1'b1;
    c0 = cyc;
    @(negedge clk);
    write_req = 1'b0;
    check("wr_busy", debug[0], 1);
    run_frame(1'b0, 16'h0, -1, bits, oes, done_seen, dv_seen, rd_at_done, cyc_done, ok);
    check("wr_ok", ok, 1);
    check("wr_bits", bits, 64'hFFFFFFFF_50DA0012);
    check("wr_oe", oes, 64'hFFFFFFFF_FFFFFFFF);
    check("wr_done", done_seen, 1);
    check("wr_dv", dv_seen, 0);
    lat = cyc_done - c0 - 1;
    check("wr_latency", (lat >= 12800 && lat <= 13000), 1);
    @(negedge clk);
    check("wr_oe_after", debug[1], 0);
    check("wr_done_after", done, 0);
    check("wr_idle_after", debug[0], 0);
    check("wr_done_cnt", done_cnt - dc0, 1);

    // Read with late register address and an ignored mid-frame request
    dc0 = done_cnt;
    dv0 = dv_cnt;
    phy_addr = 5'd1;
    reg_addr = 5'd0;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    @(negedge clk);
    reg_addr = 5'h14;
    run_frame(1'b1, 16'h8000, 20, bits, oes, done_seen, dv_seen, rd_at_done, cyc_done, ok);
    check("rd_ok", ok, 1);
    check("rd_bits", bits, 64'hFFFFFFFF_60D08000);
    check("rd_oe", oes, 64'hFFFFFFFF_FFFC0000);
    check("rd_done", done_seen, 1);
    check("rd_dv", dv_seen, 1);
    check("rd_data", rd_at_done, 16'h8000);
    @(negedge clk);
    check("rd_hold", read_data, 16'h8000);
    check("rd_oe_after", debug[1], 0);
    repeat (500) @(negedge clk);
    check("busy_ignored_idle", debug[0], 0);
    check("busy_done_cnt", done_cnt - dc0, 1);
    check("busy_dv_cnt", dv_cnt - dv0, 1);

    // Simultaneous requests: write wins
    dv0 = dv_cnt;
    phy_addr = 5'd3;
    reg_addr = 5'd1;
    write_data = 16'hA5C3;
    write_req = 1'b1;
    read_req = 1'b1;
    @(negedge clk);
    write_req = 1'b0;
    read_req = 1'b0;
    run_frame(1'b0, 16'h0, -1, bits, oes, done_seen, dv_seen, rd_at_done, cyc_done, ok);
    check("sim_ok", ok, 1);
    check("sim_bits", bits, 64'hFFFFFFFF_5186A5C3);
    check("sim_done", done_seen, 1);
    check("sim_dv", dv_seen, 0);
    check("sim_rd_hold", rd_at_done, 16'h8000);
    @(negedge clk);
    check("sim_dv_cnt", dv_cnt - dv0, 0);

    // Reset during slot 40 of a write
    phy_addr = 5'd2;
    reg_addr = 5'h1F;
    write_data = 16'h1234;
    write_req = 1'b1;
    @(negedge clk);
    write_req = 1'b0;
    wait_shift(ok);
    check("rst_mid_shift", ok, 1);
    for (int i = 0; i <= 40; i++) begin
      wait_mdc(1'b1, 1'b0, ok);
      if (i < 40) wait_mdc(1'b0, 1'b0, ok);
    end
    check("rst_mid_reach", ok, 1);
    dc0 = done_cnt;
    dv0 = dv_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mdc", mdc, 0);
    check("rst_mid_oe", debug[1], 0);
    check("rst_mid_state", debug[7:4], 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (450) @(negedge clk);
    check("rst_mid_done_cnt", done_cnt - dc0, 0);
    check("rst_mid_dv_cnt", dv_cnt - dv0, 0);
    check("rst_mid_idle", debug[0], 0);

    // Complete frame after the aborted one
    write_req = 1'b1;
    @(negedge clk);
    write_req = 1'b0;
    run_frame(1'b0, 16'h0, -1, bits, oes, done_seen, dv_seen, rd_at_done, cyc_done, ok);
    check("post_ok", ok, 1);
    check("post_bits", bits, 64'hFFFFFFFF_517E1234);
    check("post_oe", oes, 64'hFFFFFFFF_FFFFFFFF);
    check("post_done", done_seen, 1);
    check("post_rd_reset", rd_at_done, 16'h0000);
    @(negedge clk);
    check("post_oe_after", debug[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
